// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle for one elastic pipeline stage.
// The stage itself connects through the slave modport.
// Whatever drives and consumes the stage connects through the master modport.
interface pipe_stage_elastic_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             flush;
    logic [CNT_W-1:0] count;

    modport slave (
        input  in_valid, in_data, out_ready, flush,
        output in_ready, out_valid, out_data, count
    );

    modport master (
        output in_valid, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: a DEPTH-entry in-order buffer for an opaque
// WIDTH-bit stage payload.
// It uses valid/ready on both sides and a synchronous flush for squashing.
// While the stage is empty it drives the BUBBLE (NOP) payload.
// All outputs come from registered state only. There is no combinational
// path from in_data or out_ready to any output.
module pipe_stage_elastic #(
    parameter int               WIDTH  = 32,
    parameter int               DEPTH  = 2,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input logic                 clk,
    input logic                 rst,
    pipe_stage_elastic_if.slave bus
);
    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_r;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Readiness depends only on occupancy.
    // As a result, a full stage refuses a push even in a cycle where it pops.
    assign full  = (count_r == FULL_CNT);
    assign empty = (count_r == '0);

    // A flush or a reset discards any handshake offered in the same cycle.
    assign push = !rst && !bus.flush && bus.in_valid && !full;
    assign pop  = !rst && !bus.flush && bus.out_ready && !empty;

    // Pointers wrap explicitly, so DEPTH does not need to be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy bookkeeping; reset wins over flush, flush over traffic
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Payload storage is written only on an accepted push and is never cleared
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? BUBBLE : mem[rd_ptr];
    assign bus.count     = count_r;

`ifndef SYNTHESIS
    // Occupancy never exceeds the number of entries
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count_r <= FULL_CNT);

    // An empty stage always presents the bubble payload
    a_bubble_when_empty: assert property (@(posedge clk) disable iff (rst)
        !bus.out_valid |-> bus.out_data == BUBBLE);

    // A push offered while full must not change occupancy unless a pop happens
    a_no_silent_push: assert property (@(posedge clk) disable iff (rst)
        (bus.in_valid && full && !pop && !bus.flush) |=> count_r == FULL_CNT);
`endif
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Testbench for pipe_stage_elastic.
// Three instances share one input stream: DEPTH=1, DEPTH=2 and DEPTH=3.
// Each instance has its own bubble value.
// After every clock edge, every instance is compared against a queue model
// of an in-order buffer with capacity DEPTH.
module tb_pipe_stage_elastic;
    typedef logic [31:0] word_t;
    typedef word_t       word_q_t[$];

    localparam word_t BUB1 = 32'h0000_0013;
    localparam word_t BUB2 = 32'h0000_0000;
    localparam word_t BUB3 = 32'hDEAD_BEEF;

    logic  clk = 1'b0;
    logic  rst;
    logic  in_valid;
    logic  out_ready;
    logic  flush;
    word_t in_data;

    word_q_t m1;
    word_q_t m2;
    word_q_t m3;
    int      checks = 0;
    int      errors = 0;

    // Free-running clock
    always #5 clk = ~clk;

    pipe_stage_elastic_if #(.WIDTH(32), .DEPTH(1)) if1 ();
    pipe_stage_elastic_if #(.WIDTH(32), .DEPTH(2)) if2 ();
    pipe_stage_elastic_if #(.WIDTH(32), .DEPTH(3)) if3 ();

    assign if1.in_valid  = in_valid;
    assign if1.in_data   = in_data;
    assign if1.out_ready = out_ready;
    assign if1.flush     = flush;
    assign if2.in_valid  = in_valid;
    assign if2.in_data   = in_data;
    assign if2.out_ready = out_ready;
    assign if2.flush     = flush;
    assign if3.in_valid  = in_valid;
    assign if3.in_data   = in_data;
    assign if3.out_ready = out_ready;
    assign if3.flush     = flush;

    pipe_stage_elastic #(.WIDTH(32), .DEPTH(1), .BUBBLE(BUB1)) u_d1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );
    pipe_stage_elastic #(.WIDTH(32), .DEPTH(2), .BUBBLE(BUB2)) u_d2 (
        .clk (clk),
        .rst (rst),
        .bus (if2.slave)
    );
    pipe_stage_elastic #(.WIDTH(32), .DEPTH(3), .BUBBLE(BUB3)) u_d3 (
        .clk (clk),
        .rst (rst),
        .bus (if3.slave)
    );

    // One clock edge of an ideal buffer of the given capacity.
    // Readiness is decided from the occupancy before the edge.
    function automatic word_q_t stepQ(input word_q_t q, input int depth);
        bit canPush;
        bit canPop;
        canPush = (q.size() < depth);
        canPop  = (q.size() != 0);
        if (rst || flush) begin
            q.delete();
        end else begin
            if (canPop && out_ready) void'(q.pop_front());
            if (canPush && in_valid) q.push_back(in_data);
        end
        return q;
    endfunction

    task automatic checkOne(input string tag, input word_q_t q, input int depth,
                            input word_t bubble, input logic iRdy, input logic oVld,
                            input word_t oData, input logic [3:0] cnt);
        logic       expRdy;
        logic       expVld;
        word_t      expData;
        logic [3:0] expCnt;
        expRdy  = (q.size() < depth);
        expVld  = (q.size() != 0);
        expData = expVld ? q[0] : bubble;
        expCnt  = 4'(q.size());
        checks++;
        assert (iRdy === expRdy) else begin
            errors++;
            $error("[TB] FAIL %s.in_ready observed=%b expected=%b t=%0t", tag, iRdy, expRdy, $time);
        end
        checks++;
        assert (oVld === expVld) else begin
            errors++;
            $error("[TB] FAIL %s.out_valid observed=%b expected=%b t=%0t", tag, oVld, expVld, $time);
        end
        checks++;
        assert (oData === expData) else begin
            errors++;
            $error("[TB] FAIL %s.out_data observed=%h expected=%h t=%0t", tag, oData, expData, $time);
        end
        checks++;
        assert (cnt === expCnt) else begin
            errors++;
            $error("[TB] FAIL %s.count observed=%0d expected=%0d t=%0t", tag, cnt, expCnt, $time);
        end
    endtask

    task automatic checkOutput();
        checkOne("d1", m1, 1, BUB1, if1.in_ready, if1.out_valid, if1.out_data, 4'(if1.count));
        checkOne("d2", m2, 2, BUB2, if2.in_valid === 1'bx ? 1'bx : if2.in_ready,
                 if2.out_valid, if2.out_data, 4'(if2.count));
        checkOne("d3", m3, 3, BUB3, if3.in_ready, if3.out_valid, if3.out_data, 4'(if3.count));
    endtask

    // Drive one cycle of inputs, advance the models at the edge, check just after
    task automatic applyStimulus(input logic iv, input word_t id, input logic ordy,
                                 input logic fl, input logic r);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        m1 = stepQ(m1, 1);
        m2 = stepQ(m2, 2);
        m3 = stepQ(m3, 3);
        #1;
        checkOutput();
    endtask

    // Directed scenarios first, then a randomized soak
    initial begin
        int n;
        int guard;
        $display("[TB] starting");

        // Power-on reset
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of traffic, then a lone push
        applyStimulus(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hAAAA_0002, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hAAAA_0003, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Streaming with the consumer always ready
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 32'h10 + word_t'(i), 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Backpressure until full, then drain
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, word_t'(i), 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Pointer wrap: payloads 0..9 into the 3-deep stage with random stalls
        n = 0;
        guard = 0;
        while (n < 10 && guard < 200) begin
            logic accept;
            accept = (m3.size() < 3);
            applyStimulus(1'b1, word_t'(n), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (accept) n++;
            guard++;
        end
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush while both a push and a pop are offered
        applyStimulus(1'b1, 32'hB0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hB2, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Single-entry stage under continuous offer: payload advances only on acceptance
        n = 1;
        guard = 0;
        while (n <= 3 && guard < 50) begin
            logic accept;
            accept = (m1.size() < 1);
            applyStimulus(1'b1, word_t'(n), 1'b1, 1'b0, 1'b0);
            if (accept) n++;
            guard++;
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Randomized soak with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), $urandom(),
                          1'($urandom_range(0, 2) != 0),
                          1'($urandom_range(0, 19) == 0),
                          1'($urandom_range(0, 49) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised elastic pipeline register that replaces the fixed-width D/A/M/W stage registers with one reusable block. It carries an opaque packed payload of WIDTH bits (any stage cable struct) through a DEPTH-entry in-order buffer. The buffer has a valid/ready handshake on both sides, a synchronous flush for branch/jump squash, and a configurable bubble payload driven whenever the stage is empty. Instantiated between every pair of core pipeline stages.

Parameters:
WIDTH, 32, payload width in bits (>=1); set to the bit width of the stage cable struct.
DEPTH, 2, buffer entries (1..8); DEPTH>=2 gives full throughput; DEPTH=1 gives a plain stall-able register at half throughput.
BUBBLE, '0, WIDTH-bit payload driven on out_data when empty or after flush (NOP encoding).

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream has a payload
in_ready  out  1  stage can accept; in_valid&&in_ready = push
in_data  in  WIDTH  upstream payload
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts; out_valid&&out_ready = pop
out_data  out  WIDTH  head payload, BUBBLE when out_valid=0
flush  in  1  squash all entries this cycle
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Storage: DEPTH-entry circular buffer with rd_ptr, wr_ptr and count registers. Pointers wrap from DEPTH-1 to 0, including non-power-of-2 DEPTH.
- Reset (rst=1 at edge): count=0, rd_ptr=0, wr_ptr=0. Outputs the following cycle: out_valid=0, out_data=BUBBLE, in_ready=1, count=0. Entry contents need not be cleared. rst has priority over flush, push and pop.
- in_ready = (count < DEPTH). It depends only on registered state, with no combinational path from out_ready. Consequently, when full, a simultaneous pop does not admit a push that cycle.
- out_valid = (count != 0).
- out_data = buffer[rd_ptr] when out_valid, else BUBBLE. Both are registered-state driven, with no combinational path from in_data.
- Latency: a push at edge N is visible on out_valid/out_data after edge N (1-cycle latency) when the buffer was empty.
- Push only: write at wr_ptr, wr_ptr++, count++.
- Pop only: rd_ptr++, count--.
- Push and pop same cycle: both pointers advance, count unchanged. This is legal at any count in 1..DEPTH-1, and at count=0 only if no pop occurs (pop requires out_valid).
- Ordering: strict FIFO; payloads never duplicated, dropped (except by flush) or reordered.
- Flush (flush=1, rst=0): count=0, rd_ptr=wr_ptr=0. Any push or pop that cycle is discarded, including in_valid&&in_ready. Next cycle: out_valid=0, out_data=BUBBLE, in_ready=1. Upstream must treat a payload offered during flush as squashed.
- Throughput: DEPTH>=2 sustains one transfer per cycle with out_ready held high. DEPTH=1 alternates full/empty, so at most one transfer every 2 cycles.
- No handshake violations tolerated in input: in_data sampled only on push; out_ready ignored when out_valid=0.
- Assertions (sim only): count<=DEPTH; out_data==BUBBLE whenever !out_valid; no push when !in_ready is silently accepted.

Test Plan:
- Reset mid-traffic: fill 2 entries (0xAAAA0001, 0xAAAA0002), assert rst 1 cycle -> next cycle out_valid=0, out_data=BUBBLE, count=0, in_ready=1; a subsequent push of 0x5 appears alone at output.
- Streaming, DEPTH=2, out_ready=1: push 0x10,0x11,...,0x1F on consecutive cycles -> out_data shows 0x10..0x1F on consecutive cycles starting 1 cycle after first push, count stays <=1, in_ready never drops.
- Backpressure/full, DEPTH=3: out_ready=0, push 0x1,0x2,0x3,0x4 -> in_ready=0 after third push, 0x4 not accepted, count=3. Then out_ready=1 -> pops 0x1,0x2,0x3 in order; in_ready returns 1 the cycle after first pop.
- Wrap-around, DEPTH=3: 10 push/pop cycles with random out_ready stalls, payloads 0..9 -> output sequence exactly 0..9, pointers wrap through index 2->0 without loss.
- Flush with simultaneous push/pop: count=2 (0xB0,0xB1), assert flush with in_valid=1 (0xB2) and out_ready=1 -> next cycle count=0, out_valid=0, out_data=BUBBLE; 0xB2 never emerges.
- DEPTH=1, BUBBLE=32'h00000013: continuous in_valid with out_ready=1, payloads 0x1,0x2,0x3 -> in_ready toggles 1,0,1,...; outputs 0x1,0x2,0x3 one every 2 cycles; idle cycles show 0x00000013.
